// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode 7-segment scanner: one BCD digit lit per slot, with
// leading-zero blanking, per-digit blink and a dark guard cycle at every digit switch.
module seg7_scan_display #(
    parameter int NB_DIGITS      = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_HALF     = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NB_DIGITS-1:0] digits,
    input  logic                   blankLeading,
    input  logic [NB_DIGITS-1:0]   blinkMask,
    input  logic [NB_DIGITS-1:0]   dpMask,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NB_DIGITS-1:0]   an,
    output logic                   frameTick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int IW = (NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NB_DIGITS - 1);

    // XOR masks: an active-high pattern XOR the mask gives the pin level, and the
    // mask itself is the "everything off" level.
    localparam logic [6:0]           SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                 DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NB_DIGITS-1:0] AN_OFF  = {NB_DIGITS{AN_ACTIVE_LOW}};

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 guard_q, guard_d;
    logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [NB_DIGITS-1:0] an_q, an_d;

    logic [3:0]           digit_val [NB_DIGITS];
    logic [NB_DIGITS-1:0] lead_blank;
    logic                 zero_run;
    logic                 cnt_wrap;
    logic                 blink_wrap;
    logic                 digit_hidden;
    logic [6:0]           seg_hi;
    logic [NB_DIGITS-1:0] an_hi;

    genvar gi;
    generate
        for (gi = 0; gi < NB_DIGITS; gi++) begin : g_digit
            assign digit_val[gi] = digits[4*gi +: 4];
        end
    endgenerate

    // A digit is a leading zero when it and every more significant digit are zero;
    // digit 0 always stays visible so a value of zero still shows "0".
    always_comb begin
        lead_blank = '0;
        zero_run   = 1'b1;
        for (int i = NB_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (digit_val[i] == 4'd0);
            lead_blank[i] = blankLeading & zero_run & (i != 0);
        end
    end

    always_comb begin
        cnt_wrap      = (cnt_q == CNT_MAX);
        cnt_d         = cnt_wrap ? '0 : cnt_q + CW'(1);
        idx_d         = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
        guard_d       = cnt_wrap;
        frame_tick_d  = cnt_wrap & (idx_q == IDX_MAX);

        blink_wrap    = (blink_cnt_q == BLINK_MAX);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q ^ blink_wrap;

        digit_hidden  = lead_blank[idx_q] | (blink_phase_q & blinkMask[idx_q]);
        seg_hi        = bcd_to_seg(digit_val[idx_q]);
        an_hi         = '0;
        an_hi[idx_q]  = 1'b1;

        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
        an_d  = AN_OFF;
        if (!guard_q && !digit_hidden) begin
            seg_d = seg_hi ^ SEG_OFF;
            dp_d  = dpMask[idx_q] ^ DP_OFF;
            an_d  = an_hi ^ AN_OFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            guard_q       <= 1'b1;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            frame_tick_q  <= 1'b0;
            seg_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            an_q          <= AN_OFF;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            guard_q       <= guard_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            frame_tick_q  <= frame_tick_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign frameTick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display (4 digits, 4-cycle slots, 64-cycle blink).
// Expected per-cycle outputs are queued per frame; a monitor pops them on negedges.
module tb_seg7_scan_display;

    localparam int NB = 4;

    localparam logic [6:0] S0    = 7'h40;
    localparam logic [6:0] S1    = 7'h79;
    localparam logic [6:0] S2    = 7'h24;
    localparam logic [6:0] S3    = 7'h30;
    localparam logic [6:0] S4    = 7'h19;
    localparam logic [6:0] S5    = 7'h12;
    localparam logic [6:0] S7    = 7'h78;
    localparam logic [6:0] SDASH = 7'h3F;
    localparam logic [6:0] SX    = 7'h7F;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   digits = 16'h1234;
    logic          blankLeading = 1'b0;
    logic [NB-1:0] blinkMask = '0;
    logic [NB-1:0] dpMask = '0;
    logic [6:0]    seg;
    logic          dp;
    logic [NB-1:0] an;
    logic          frameTick;

    seg7_scan_display #(
        .NB_DIGITS(NB), .SCAN_DIV(4), .BLINK_HALF(64),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .digits(digits), .blankLeading(blankLeading),
        .blinkMask(blinkMask), .dpMask(dpMask),
        .seg(seg), .dp(dp), .an(an), .frameTick(frameTick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        int         tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
        logic       chk_seg;
        logic       chk_dp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic imm_req = 1'b0;
    logic imm_mode = 1'b0;
    exp_t imm_exp;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic push(input int c, input int tag, input logic [3:0] a, input logic [6:0] s,
                        input logic d, input logic ft, input logic cs, input logic cd);
        exp_t e;
        e.cyc = c; e.tag = tag; e.an = a; e.seg = s; e.dp = d; e.ft = ft;
        e.chk_seg = cs; e.chk_dp = cd;
        q.push_back(e);
    endtask

    // One slot: a dark guard cycle followed by three cycles of the given digit.
    task automatic push_slot(input int f, input int s, input int tag, input logic [3:0] a,
                             input logic [6:0] sg, input logic d, input logic cs, input logic cd);
        int k0;
        k0 = 16 * f + 4 * s + 1;
        push(k0, tag, 4'hF, SX, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int r = 1; r <= 3; r++) push(k0 + r, tag, a, sg, d, (s == 3 && r == 3), cs, cd);
    endtask

    // segs = {slot3, slot2, slot1, slot0}; hid marks dark slots, hid_dp those whose dp is checked off.
    task automatic push_frame(input int f, input int tag, input logic [27:0] segs,
                              input logic [3:0] dps, input logic [3:0] hid, input logic [3:0] hid_dp);
        logic [3:0] lit;
        for (int s = 0; s < 4; s++) begin
            lit = 4'hF;
            lit[s] = 1'b0;
            if (hid[s]) push_slot(f, s, tag, 4'hF, SX, 1'b1, 1'b0, hid_dp[s]);
            else        push_slot(f, s, tag, lit, segs[7*s +: 7], ~dps[s], 1'b1, 1'b1);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic imm_check(input int tag, input logic [3:0] a, input logic [6:0] s,
                             input logic d, input logic ft);
        imm_exp = '{cyc: cyc, tag: tag, an: a, seg: s, dp: d, ft: ft, chk_seg: 1'b1, chk_dp: 1'b1};
        imm_mode = 1'b0;
        imm_req = 1'b1;
        #1 imm_req = 1'b0;
    endtask

    // Monitor: the only process that compares and counts.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge imm_req);
            if (imm_req && imm_mode) begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: %0d expectations left, required 0", q.size());
                end else
                    $display("ok drain: scoreboard empty");
            end else if (imm_req) begin
                checks++;
                e = imm_exp;
                if (an !== e.an || seg !== e.seg || dp !== e.dp || frameTick !== e.ft) begin
                    errors++;
                    $display("FAIL imm tag%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b",
                             e.tag, an, seg, dp, frameTick, e.an, e.seg, e.dp, e.ft);
                end else
                    $display("ok imm tag%0d an=%b seg=%b dp=%b ft=%b", e.tag, an, seg, dp, frameTick);
            end else begin
                while (q.size() > 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    checks++;
                    if (e.cyc != cyc) begin
                        errors++;
                        $display("FAIL stale tag%0d: expectation for cycle %0d seen at cycle %0d",
                                 e.tag, e.cyc, cyc);
                    end else if (an !== e.an || (e.chk_seg && seg !== e.seg) ||
                                 (e.chk_dp && dp !== e.dp) || frameTick !== e.ft) begin
                        errors++;
                        $display("FAIL scan tag%0d cyc %0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b(chk %b) dp=%b(chk %b) ft=%b",
                                 e.tag, cyc, an, seg, dp, frameTick, e.an, e.seg, e.chk_seg,
                                 e.dp, e.chk_dp, e.ft);
                    end else
                        $display("ok tag%0d cyc %0d an=%b seg=%b dp=%b ft=%b",
                                 e.tag, cyc, an, seg, dp, frameTick);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        // Plain scan of 1234.
        push_frame(0, 1, {S1, S2, S3, S4}, 4'b0000, 4'b0000, 4'b0000);
        push_frame(1, 1, {S1, S2, S3, S4}, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;

        wait_cyc(32);
        digits = 16'h0050; blankLeading = 1'b1;
        push_frame(2, 2, {SX, SX, S5, S0}, 4'b0000, 4'b1100, 4'b1100);

        wait_cyc(48);
        digits = 16'h0000;
        push_frame(3, 3, {SX, SX, SX, S0}, 4'b0000, 4'b1110, 4'b1110);

        wait_cyc(64);
        digits = 16'h1234; blankLeading = 1'b0; blinkMask = 4'b0011;
        for (int f = 4; f < 8; f++) push_frame(f, 4, {S1, S2, SX, SX}, 4'b0000, 4'b0011, 4'b0000);
        push_frame(8, 4, {S1, S2, S3, S4}, 4'b0000, 4'b0000, 4'b0000);

        wait_cyc(144);
        digits = 16'h00A7; blinkMask = 4'b0000; dpMask = 4'b0100;
        push_frame(9, 5, {S0, S0, SDASH, S7}, 4'b0100, 4'b0000, 4'b0000);

        // Asynchronous reset in the middle of digit 0's slot.
        wait_cyc(162);
        #2;
        imm_check(6, 4'b1110, S7, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        imm_check(7, 4'hF, SX, 1'b1, 1'b0);

        digits = 16'h1234; dpMask = 4'b0000;
        repeat (3) @(negedge clk);
        for (int f = 0; f < 3; f++) push_frame(f, 8, {S1, S2, S3, S4}, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;

        wait_cyc(48);
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        #1;
        imm_mode = 1'b1;
        imm_req = 1'b1;
        #1 imm_req = 1'b0;
        imm_mode = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
